// File: rtl/spi_master.sv
// spi_master: single-byte, full-duplex, MSB-first SPI initiator.
// SCLK, CS_n and MOSI are generated from i_clk; MISO is sampled on the
// capture edge selected by SPI_MODE. Every output is driven from a register.
// Optional build macro: SPI_MASTER_LOOPBACK_EN. When defined, the sampled
// MISO bit is taken from the registered MOSI output and i_spi_miso is ignored.
`timescale 1ns/1ps
module spi_master #(
  parameter int SPI_MODE          = 0,
  parameter int CLKS_PER_HALF_BIT = 2
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic [7:0] i_tx_byte,
  input  logic       i_tx_dv,
  output logic       o_tx_ready,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_dv,
  output logic       o_spi_clk,
  output logic       o_spi_mosi,
  input  logic       i_spi_miso,
  output logic       o_spi_csn
);

  localparam logic       CPOL     = 1'(SPI_MODE / 2);
  localparam logic       CPHA     = 1'(SPI_MODE % 2);
  localparam logic [7:0] HALF_MAX = 8'(CLKS_PER_HALF_BIT - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [4:0] edge_q, edge_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       sclk_q, sclk_d;
  logic       mosi_q, mosi_d;
  logic       csn_q, csn_d;
  logic       ready_q, ready_d;
  logic       rx_dv_q, rx_dv_d;

  logic       accept;
  logic       half_done;
  logic [4:0] edge_nx;
  logic       sample_edge;
  logic       miso_s;

`ifdef SPI_MASTER_LOOPBACK_EN
  // Loopback: capture our own registered MOSI; the pin is left unconnected.
  logic unused_miso;
  assign unused_miso = i_spi_miso;
  assign miso_s      = mosi_q;
`else
  assign miso_s      = i_spi_miso;
`endif

  assign accept    = (state_q == IDLE) && i_tx_dv && ready_q;
  assign half_done = (cnt_q == HALF_MAX);
  assign edge_nx   = edge_q + 5'd1;
  // CPHA=0 captures on leading (odd) edges, CPHA=1 on trailing (even) edges.
  assign sample_edge = edge_nx[0] ^ CPHA;

  // State register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic: each timed phase ends when the half-bit counter wraps.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept) state_d = SETUP;
      SETUP: if (half_done) state_d = SHIFT;
      SHIFT: if (half_done && (edge_nx == 5'd16)) state_d = HOLD;
      HOLD:  if (half_done) state_d = GAP;
      GAP:   if (half_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values; SETUP's wrap produces SCLK edge 1.
  always_comb begin
    cnt_d     = (state_q == IDLE || half_done) ? 8'd0 : cnt_q + 8'd1;
    edge_d    = edge_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rx_byte_d = rx_byte_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    csn_d     = csn_q;
    ready_d   = ready_q;
    rx_dv_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          csn_d   = 1'b0;
          ready_d = 1'b0;
          edge_d  = 5'd0;
          rx_d    = 8'h00;
          if (CPHA) begin
            tx_d = i_tx_byte;
          end else begin
            // Bit 7 must be on the wire before the first (capturing) edge.
            mosi_d = i_tx_byte[7];
            tx_d   = {i_tx_byte[6:0], 1'b0};
          end
        end
      end
      SETUP, SHIFT: begin
        if (half_done) begin
          sclk_d = ~sclk_q;
          edge_d = edge_nx;
          if (sample_edge) begin
            rx_d = {rx_q[6:0], miso_s};
          end else if (edge_nx != 5'd16) begin
            // Launch edge; edge 16 would be past the last bit for CPHA=0.
            mosi_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
          end
        end
      end
      HOLD: begin
        if (half_done) begin
          csn_d     = 1'b1;
          rx_dv_d   = 1'b1;
          rx_byte_d = rx_q;
        end
      end
      GAP: begin
        if (half_done) ready_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Output, counter and shift registers; reset discards any partial byte.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt_q     <= 8'd0;
      edge_q    <= 5'd0;
      tx_q      <= 8'h00;
      rx_q      <= 8'h00;
      rx_byte_q <= 8'h00;
      sclk_q    <= CPOL;
      mosi_q    <= 1'b0;
      csn_q     <= 1'b1;
      ready_q   <= 1'b1;
      rx_dv_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      edge_q    <= edge_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rx_byte_q <= rx_byte_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      csn_q     <= csn_d;
      ready_q   <= ready_d;
      rx_dv_q   <= rx_dv_d;
    end
  end

  assign o_tx_ready = ready_q;
  assign o_rx_byte  = rx_byte_q;
  assign o_rx_dv    = rx_dv_q;
  assign o_spi_clk  = sclk_q;
  assign o_spi_mosi = mosi_q;
  assign o_spi_csn  = csn_q;

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: four spi_master instances (modes 0,3,1,2) checked every
// cycle against a timeline model (cycle number since accept -> expected pins),
// plus literal expectations for the directed transfers.
`timescale 1ns/1ps
module tb_spi_master;

  localparam int NI = 4;
  localparam int MODES [NI] = '{0, 3, 1, 2};
  localparam int CH    [NI] = '{2, 4, 3, 2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn    [NI];
  logic [7:0] tx_byte [NI];
  logic       tx_dv   [NI];
  logic       miso    [NI];
  logic       rdy     [NI];
  logic [7:0] rxb     [NI];
  logic       dv      [NI];
  logic       sclk    [NI];
  logic       mosi    [NI];
  logic       csn     [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    spi_master #(.SPI_MODE(MODES[g]), .CLKS_PER_HALF_BIT(CH[g])) u_dut (
      .i_clk      (clk),
      .i_rstn     (rstn[g]),
      .i_tx_byte  (tx_byte[g]),
      .i_tx_dv    (tx_dv[g]),
      .o_tx_ready (rdy[g]),
      .o_rx_byte  (rxb[g]),
      .o_rx_dv    (dv[g]),
      .o_spi_clk  (sclk[g]),
      .o_spi_mosi (mosi[g]),
      .i_spi_miso (miso[g]),
      .o_spi_csn  (csn[g])
    );
  end

  // Model state: t_m = cycles since accept (0 = idle).
  int         t_m     [NI];
  logic [7:0] cur_tx  [NI];
  logic [7:0] cur_sl  [NI];
  logic [7:0] next_sl [NI];
  logic [7:0] last_rx [NI];
  logic       e_csn [NI], e_sclk [NI], e_mosi [NI], e_rdy [NI], e_dv [NI];
  logic [7:0] e_rxb [NI];

  logic       req_dv   [NI];
  logic [7:0] req_byte [NI];

  // Pin observations for literal checks.
  logic       prev_sclk [NI];
  logic [7:0] obs_bits  [NI];
  int         obs_rises [NI];

  int n_pass = 0;
  int n_tot  = 0;

  function automatic logic cpol(int i); return MODES[i] >= 2; endfunction
  function automatic logic cpha(int i); return (MODES[i] % 2) == 1; endfunction
  function automatic int tend(int i); return 1 + 18 * CH[i]; endfunction
  function automatic int imin(int a, int b); return (a < b) ? a : b; endfunction

  task automatic chk(input string nm, input int i, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s inst%0d @%0t: got 0x%0h expected 0x%0h", nm, i, $time, act, exp);
  endtask

  task automatic compute_exp(input int i);
    int t, c, n;
    t = t_m[i];
    c = CH[i];
    e_rxb[i] = last_rx[i];
    if (t == 0 || t == tend(i)) begin
      e_csn[i] = 1'b1; e_sclk[i] = cpol(i); e_rdy[i] = 1'b1; e_dv[i] = 1'b0;
    end else begin
      n = (t >= 1 + c) ? imin(16, (t - 1) / c) : 0;
      e_csn[i]  = (t >= 1 + 17 * c);
      e_sclk[i] = cpol(i) ^ ((n % 2) == 1);
      e_rdy[i]  = 1'b0;
      e_dv[i]   = (t == 1 + 17 * c);
      if (!cpha(i))   e_mosi[i] = cur_tx[i][7 - imin(7, n / 2)];
      else if (n > 0) e_mosi[i] = cur_tx[i][7 - imin(7, (n - 1) / 2)];
    end
  endtask

  task automatic model_reset(input int i);
    t_m[i] = 0; last_rx[i] = 8'h00; e_mosi[i] = 1'b0;
    compute_exp(i);
  endtask

  // Advance the model by one rising edge using the inputs just applied.
  task automatic model_step(input int i);
    if (!rstn[i]) begin
      model_reset(i);
    end else begin
      if (t_m[i] == 0 || t_m[i] == tend(i)) begin
        if (tx_dv[i]) begin
          t_m[i] = 1; cur_tx[i] = tx_byte[i]; cur_sl[i] = next_sl[i];
        end else begin
          t_m[i] = 0;
        end
      end else begin
        t_m[i]++;
      end
      if (t_m[i] == 1 + 17 * CH[i]) begin
`ifdef SPI_MASTER_LOOPBACK_EN
        last_rx[i] = cur_tx[i];
`else
        last_rx[i] = cur_sl[i];
`endif
      end
      compute_exp(i);
    end
  endtask

  // Slave drives the right bit only in the cycle before each capture edge.
  function automatic logic miso_val(int i);
`ifdef SPI_MASTER_LOOPBACK_EN
    return 1'b1;
`else
    int t, c, k, j;
    t = t_m[i];
    c = CH[i];
    if (t > 0 && t < tend(i) && (t % c) == 0) begin
      k = t / c;
      if (k >= 1 && k <= 16 && (((k % 2) == 1) != cpha(i))) begin
        j = cpha(i) ? (k - 2) / 2 : (k - 1) / 2;
        return cur_sl[i][7 - j];
      end
    end
    return 1'($urandom % 2);
`endif
  endfunction

  task automatic check_outputs(input int i);
    chk("csn",     i, int'(csn[i]),  int'(e_csn[i]));
    chk("sclk",    i, int'(sclk[i]), int'(e_sclk[i]));
    chk("mosi",    i, int'(mosi[i]), int'(e_mosi[i]));
    chk("ready",   i, int'(rdy[i]),  int'(e_rdy[i]));
    chk("rx_dv",   i, int'(dv[i]),   int'(e_dv[i]));
    chk("rx_byte", i, int'(rxb[i]),  int'(e_rxb[i]));
  endtask

  // One clock: compare at the falling edge, drive, step model at rising edge.
  task automatic cycle();
    for (int i = 0; i < NI; i++) begin
      if (sclk[i] && !prev_sclk[i]) begin
        obs_bits[i] = {obs_bits[i][6:0], mosi[i]};
        if (!csn[i]) obs_rises[i]++;
      end
      prev_sclk[i] = sclk[i];
      check_outputs(i);
    end
    for (int i = 0; i < NI; i++) begin
      miso[i]    = miso_val(i);
      tx_dv[i]   = req_dv[i];
      tx_byte[i] = req_byte[i];
    end
    @(posedge clk);
    for (int i = 0; i < NI; i++) model_step(i);
    @(negedge clk);
  endtask

  task automatic async_reset(input int i);
    rstn[i] = 1'b0;
    #1;
    model_reset(i);
    check_outputs(i);
  endtask

  int dv_k0, dv_k1, rdy_k0, rdy_k1, lo0, lo1, sidle1, gap, ndv;
  logic [7:0] rx0, rx1, rx0b;
  int rel [NI];

  initial begin
    for (int i = 0; i < NI; i++) begin
      rstn[i] = 1'b0; req_dv[i] = 1'b0; req_byte[i] = 8'h00; next_sl[i] = 8'h00;
      tx_dv[i] = 1'b0; tx_byte[i] = 8'h00; miso[i] = 1'b0;
      cur_tx[i] = 8'h00; cur_sl[i] = 8'h00; rel[i] = 0;
      prev_sclk[i] = cpol(i); obs_bits[i] = 8'h00; obs_rises[i] = 0;
      model_reset(i);
    end
    @(negedge clk);
    repeat (3) cycle();
    chk("reset_csn", 0, int'(csn[0]), 1);
    chk("reset_ready", 0, int'(rdy[0]), 1);
    chk("reset_sclk_cpol1", 1, int'(sclk[1]), 1);
    chk("reset_rx_byte", 0, int'(rxb[0]), 8'h00);
    for (int i = 0; i < NI; i++) rstn[i] = 1'b1;
    repeat (2) cycle();

    // Mode 0 C=2 sends A5 (slave 3C); mode 3 C=4 sends 81 (slave 7E).
    for (int i = 0; i < NI; i++) begin obs_bits[i] = 8'h00; obs_rises[i] = 0; end
    req_dv[0] = 1'b1; req_byte[0] = 8'hA5; next_sl[0] = 8'h3C;
    req_dv[1] = 1'b1; req_byte[1] = 8'h81; next_sl[1] = 8'h7E;
    cycle();
    req_dv[0] = 1'b0; req_dv[1] = 1'b0;
    dv_k0 = 0; dv_k1 = 0; rdy_k0 = 0; rdy_k1 = 0; lo0 = 0; lo1 = 0; sidle1 = 0;
    rx0 = 8'h00; rx1 = 8'h00;
    for (int k = 1; k <= 80; k++) begin
      if (dv[0]) begin dv_k0 = k; rx0 = rxb[0]; end
      if (dv[1]) begin dv_k1 = k; rx1 = rxb[1]; end
      if (!csn[0]) lo0++;
      if (!csn[1]) lo1++;
      if (rdy[0] && rdy_k0 == 0) rdy_k0 = k;
      if (rdy[1] && rdy_k1 == 0) rdy_k1 = k;
      if (k == 1) sidle1 = int'(sclk[1]);
      req_byte[0] = 8'($urandom); req_byte[1] = 8'($urandom);
      cycle();
    end
    chk("m0_rx_dv_cycle", 0, dv_k0, 35);
    chk("m0_ready_cycle", 0, rdy_k0, 37);
    chk("m0_cs_low_cycles", 0, lo0, 34);
    chk("m0_mosi_at_rise", 0, int'(obs_bits[0]), 8'hA5);
    chk("m0_sclk_periods", 0, obs_rises[0], 8);
    chk("m3_rx_dv_cycle", 1, dv_k1, 69);
    chk("m3_ready_cycle", 1, rdy_k1, 73);
    chk("m3_cs_low_cycles", 1, lo1, 68);
    chk("m3_mosi_at_rise", 1, int'(obs_bits[1]), 8'h81);
    chk("m3_sclk_periods", 1, obs_rises[1], 8);
    chk("m3_sclk_idle_high", 1, sidle1, 1);
`ifdef SPI_MASTER_LOOPBACK_EN
    chk("m0_rx_byte", 0, int'(rx0), 8'hA5);
    chk("m3_rx_byte", 1, int'(rx1), 8'h81);
`else
    chk("m0_rx_byte", 0, int'(rx0), 8'h3C);
    chk("m3_rx_byte", 1, int'(rx1), 8'h7E);
`endif

    // Send 11 then hold tx_dv with FF: FF must start back-to-back at cycle 37.
    obs_bits[0] = 8'h00;
    req_dv[0] = 1'b1; req_byte[0] = 8'h11; next_sl[0] = 8'hC3;
    cycle();
    req_byte[0] = 8'hFF; next_sl[0] = 8'h96;
    gap = 0; ndv = 0; rx0 = 8'h00; rx0b = 8'h00;
    for (int k = 1; k <= 80; k++) begin
      if (k == 37) begin
        chk("hold_first_mosi", 0, int'(obs_bits[0]), 8'h11);
        obs_bits[0] = 8'h00;
      end
      if (k == 38) req_dv[0] = 1'b0;
      if (csn[0] && k <= 45) gap++;
      if (dv[0]) begin
        ndv++;
        if (ndv == 1) rx0 = rxb[0]; else rx0b = rxb[0];
      end
      cycle();
    end
    chk("b2b_cs_high_cycles", 0, gap, 3);
    chk("hold_second_mosi", 0, int'(obs_bits[0]), 8'hFF);
    chk("hold_rx_dv_count", 0, ndv, 2);
`ifdef SPI_MASTER_LOOPBACK_EN
    chk("hold_rx1", 0, int'(rx0), 8'h11);
    chk("hold_rx2", 0, int'(rx0b), 8'hFF);
`else
    chk("hold_rx1", 0, int'(rx0), 8'hC3);
    chk("hold_rx2", 0, int'(rx0b), 8'h96);
`endif

    // Asynchronous reset while SCLK edge 7 is on the wire.
    req_dv[0] = 1'b1; req_byte[0] = 8'h6B; next_sl[0] = 8'hD2;
    cycle();
    req_dv[0] = 1'b0;
    for (int k = 1; k <= 14; k++) cycle();
    chk("edge7_sclk", 0, int'(sclk[0]), 1);
    async_reset(0);
    chk("midrst_csn", 0, int'(csn[0]), 1);
    chk("midrst_sclk", 0, int'(sclk[0]), 0);
    chk("midrst_rx_byte", 0, int'(rxb[0]), 8'h00);
    chk("midrst_ready", 0, int'(rdy[0]), 1);
    chk("midrst_mosi", 0, int'(mosi[0]), 0);
    cycle();
    rstn[0] = 1'b1;
    ndv = 0;
    for (int k = 0; k < 40; k++) begin
      if (dv[0]) ndv++;
      cycle();
    end
    chk("midrst_no_rx_dv", 0, ndv, 0);

    // Transfer after reset, plus 5A in mode 0 and mode 1.
    req_dv[0] = 1'b1; req_byte[0] = 8'h5A; next_sl[0] = 8'hA3;
    req_dv[2] = 1'b1; req_byte[2] = 8'h5A; next_sl[2] = 8'hA3;
    cycle();
    req_dv[0] = 1'b0; req_dv[2] = 1'b0;
    rx0 = 8'h00; rx1 = 8'h00;
    for (int k = 1; k <= 60; k++) begin
      if (dv[0]) rx0 = rxb[0];
      if (dv[2]) rx1 = rxb[2];
      cycle();
    end
`ifdef SPI_MASTER_LOOPBACK_EN
    chk("post_rst_m0_rx", 0, int'(rx0), 8'h5A);
    chk("m1_rx", 2, int'(rx1), 8'h5A);
`else
    chk("post_rst_m0_rx", 0, int'(rx0), 8'hA3);
    chk("m1_rx", 2, int'(rx1), 8'hA3);
`endif

    // Randomized traffic with occasional asynchronous resets.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NI; i++) begin
        if (rel[i] != 0) begin rstn[i] = 1'b1; rel[i] = 0; end
        req_byte[i] = 8'($urandom);
        next_sl[i]  = 8'($urandom);
        if (!req_dv[i]) req_dv[i] = ($urandom_range(0, 9) == 0);
        else            req_dv[i] = ($urandom_range(0, 3) != 0);
      end
      if ($urandom_range(0, 399) == 0) begin
        int r;
        r = int'($urandom_range(0, NI - 1));
        async_reset(r);
        rel[r] = 1;
      end
      cycle();
    end
    for (int i = 0; i < NI; i++) begin rstn[i] = 1'b1; req_dv[i] = 1'b0; end
    repeat (80) cycle();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
